alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

- Shares the single-cycle combinational ALU between two requesters: requester 0 is the integer pipeline, requester 1 is the address/branch-compare unit.
- Arbitrates with round-robin priority and registers operands into the ALU.
- Captures `result`/`zero` into a response register and returns them to the winner over a valid/ready handshake.
- Serves one operation in flight at a time.

## Interface

Parameters:
- `TAG_W`, default 4: width of the requester-supplied tag echoed on the response.

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  2  request valid, bit i = requester i
- `req_ready`  out  2  request accepted when `req_valid[i] & req_ready[i]`
- `req_a0`, `req_a1`  in  32  operand a per requester
- `req_b0`, `req_b1`  in  32  operand b per requester
- `req_ctrl0`, `req_ctrl1`  in  4  ALUControl code per requester
- `req_tag0`, `req_tag1`  in  TAG_W  tag per requester
- `alu_a`, `alu_b`  out  32  registered operands to the ALU
- `alu_ctrl`  out  4  registered ALUControl to the ALU
- `alu_result`  in  32  ALU result
- `alu_zero`  in  1  ALU zero flag
- `rsp_valid`  out  2  response valid, bit i = requester i, one-hot or zero
- `rsp_ready`  in  2  response consumed when `rsp_valid[i] & rsp_ready[i]`
- `rsp_result`  out  32  captured result
- `rsp_zero`  out  1  captured zero flag
- `rsp_err`  out  1  illegal-opcode flag (see Configuration)
- `rsp_tag`  out  TAG_W  tag of the served request

## Operation

FSM states and transitions:
- IDLE -> EXEC on an accepted request.
- EXEC -> RESP unconditionally.
- RESP -> IDLE on response handshake.

Grant (combinational, IDLE only):
- Exactly one valid requester: that requester wins.
- Both valid: the requester named by priority pointer `prio` wins.
- `req_ready[i]` = (state==IDLE) & grant[i]. At most one ready bit is high; ready is never high outside IDLE.

On acceptance:
- Latch the winner's a, b, ctrl and tag into the `alu_a`/`alu_b`/`alu_ctrl` registers and the tag register.
- Record the winner index `own`.
- Set `prio` to the index that did not win.

EXEC:
- ALU sees the registered operands.
- At the end of the cycle, capture `alu_result`, `alu_zero` and `rsp_err` into the response registers.

RESP:
- `rsp_valid[own]`=1; the other bit is 0.
- Response registers stay stable until handshake.
- `rsp_ready` of the non-owner is ignored.

Operand registers hold their last value in IDLE and RESP. The ALU output is not sampled there.

Reset:
- state=IDLE, `prio`=0, `own`=0.
- `alu_a`=`alu_b`=0, `alu_ctrl`=4'b0010 (ADD).
- `rsp_result`=0, `rsp_zero`=0, `rsp_err`=0, `rsp_tag`=0.
- `rsp_valid`=0, `req_ready`=0 while `rst_n` low.
- Reset asserted in EXEC or RESP drops the in-flight operation silently; no response is ever produced for it.

## Timing

- Cycle 0 (IDLE): handshake.
- Cycle 1 (EXEC): `alu_*` outputs show the new operands.
- Cycle 2 onward (RESP): `rsp_valid` high; earliest response handshake in cycle 2.
- Back to IDLE the cycle after the response handshake.
- Minimum spacing between accepted requests is 3 cycles.
- `rsp_valid` and `req_ready` are never high in the same cycle.
- `req_ready` depends combinationally on `req_valid` and state only; it never depends on `rsp_ready`.
- Requesters must hold a, b, ctrl and tag stable while valid and not ready; the block samples them only on handshake.
- Withdrawing `req_valid` before the handshake is allowed and causes no grant.
- Back-to-back contention alternates strictly: 0,1,0,1…

## Configuration

Macro `ALU_ARB_OPCHECK_EN`:
- Defined:
  - Legal codes are 0000, 0001, 0010, 0100, 0101, 0110, 0111, 1101.
  - An accepted illegal code still walks IDLE->EXEC->RESP.
  - `alu_ctrl` is forced to 0010 in EXEC.
  - Response is `rsp_result`=0, `rsp_zero`=1, `rsp_err`=1.
- Undefined:
  - Code is passed through unchanged.
  - `rsp_err` is tied 0.
  - `rsp_result`/`rsp_zero` are whatever the ALU returns, including X.

## Test plan

- **Reset values:** reset mid-RESP with `rsp_valid`=2'b01 -> next cycle `rsp_valid`=0, all outputs at reset values, and a request in the cycle after reset release is granted to requester 0.
- **Single request, requester 0:** ADD a=5, b=7, tag=3 -> `alu_ctrl`=0010 in cycle 1; `rsp_valid`=01, `rsp_result`=12, `rsp_zero`=0, `rsp_tag`=3 in cycle 2.
- **Contention:** both valid continuously, requester 0 SUB 9-9, requester 1 SLT a=-1, b=1 -> grants alternate 0,1,0.
  - Requester 0 gets `rsp_result`=0, `rsp_zero`=1.
  - Requester 1 gets `rsp_result`=1, `rsp_zero`=0.
  - `prio` toggles on every grant.
- **Response backpressure:** `rsp_ready`=0 for 5 cycles on an SRA a=0x80000000, b=4 -> `rsp_result`=0xF8000000 held stable, `req_ready`=00 throughout; IDLE one cycle after `rsp_ready`=1.
- **Illegal opcode:** ctrl=4'b1111 with `ALU_ARB_OPCHECK_EN` defined -> `rsp_err`=1, `rsp_result`=0, `rsp_zero`=1. Without the macro, `rsp_err`=0.
- **Valid withdrawn:** requester 1 asserts valid while the FSM is in EXEC and drops it before IDLE -> no grant and no `rsp_valid[1]`.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
//
// Purpose:
//   Requester 0 (integer pipeline) and requester 1 (address/branch-compare
//   unit) share a single-cycle combinational ALU. One operation is in flight
//   at a time and walks IDLE -> EXEC -> RESP.
//   - IDLE: combinational grant (round-robin on contention). The winner's
//     operands are latched on the request handshake.
//   - EXEC: the ALU sees the registered operands. Its output is captured at
//     the end of the cycle.
//   - RESP: the captured response is held for the owner until the owner
//     accepts it.
//
// Optional feature:
//   ALU_ARB_OPCHECK_EN - when defined, an illegal ALUControl code is detected
//   at acceptance. The ALU is then driven with ADD, and the response is
//   result=0, zero=1, err=1. When undefined, the code passes through
//   unchanged and rsp_err is tied low.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid[1:0] / req_ready[1:0]
//                                  per-requester request handshake
//   req_a0/1, req_b0/1             32-bit operands per requester
//   req_ctrl0/1                    4-bit ALUControl per requester
//   req_tag0/1                     TAG_W tag per requester, echoed on response
//   alu_a, alu_b, alu_ctrl         registered operands to the shared ALU
//   alu_result, alu_zero           ALU outputs, sampled only in EXEC
//   rsp_valid[1:0] / rsp_ready[1:0]
//                                  per-requester response handshake (one-hot)
//   rsp_result, rsp_zero, rsp_err  captured response
//   rsp_tag                        tag of the served request

module alu_share_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [31:0]      req_a0,
  input  logic [31:0]      req_a1,
  input  logic [31:0]      req_b0,
  input  logic [31:0]      req_b1,
  input  logic [3:0]       req_ctrl0,
  input  logic [3:0]       req_ctrl1,
  input  logic [TAG_W-1:0] req_tag0,
  input  logic [TAG_W-1:0] req_tag1,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag
);

  localparam logic [3:0] CTRL_ADD = 4'b0010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   prio;   // requester that wins the next contended grant
  logic   own;    // requester owning the operation in flight

  logic [1:0]       grant;
  logic             accept;
  logic             win;
  logic [31:0]      win_a;
  logic [31:0]      win_b;
  logic [3:0]       win_ctrl;
  logic [TAG_W-1:0] win_tag;
  logic [3:0]       ctrl_load;
  logic [31:0]      cap_result;
  logic             cap_zero;

  // Grant exists only in IDLE. With both requesters valid, prio picks the winner.
  always_comb begin
    grant = 2'b00;
    if (state == IDLE) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // The FSM already sits in IDLE while reset is held. Gating with rst_n keeps
  // ready low throughout reset instead of echoing req_valid.
  assign req_ready = grant & {2{rst_n}};
  assign accept    = |grant;
  assign win       = grant[1];

  assign win_a    = win ? req_a1    : req_a0;
  assign win_b    = win ? req_b1    : req_b0;
  assign win_ctrl = win ? req_ctrl1 : req_ctrl0;
  assign win_tag  = win ? req_tag1  : req_tag0;

`ifdef ALU_ARB_OPCHECK_EN
  logic win_illegal;
  logic illegal_q;   // the operation in flight carried an illegal code

  always_comb begin
    win_illegal = 1'b1;
    case (win_ctrl)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b0101, 4'b0110, 4'b0111, 4'b1101: win_illegal = 1'b0;
      default:                            win_illegal = 1'b1;
    endcase
  end

  // Illegal codes never reach the ALU. ADD keeps its output well defined,
  // although that output is discarded.
  assign ctrl_load  = win_illegal ? CTRL_ADD : win_ctrl;
  assign cap_result = illegal_q ? 32'd0 : alu_result;
  assign cap_zero   = illegal_q ? 1'b1  : alu_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        illegal_q <= win_illegal;
      end
      if (state == EXEC) begin
        rsp_err <= illegal_q;
      end
    end
  end
`else
  assign ctrl_load  = win_ctrl;
  assign cap_result = alu_result;
  assign cap_zero   = alu_zero;
  assign rsp_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prio       <= 1'b0;
      own        <= 1'b0;
      alu_a      <= 32'd0;
      alu_b      <= 32'd0;
      alu_ctrl   <= CTRL_ADD;
      rsp_tag    <= '0;
      rsp_result <= 32'd0;
      rsp_zero   <= 1'b0;
      rsp_valid  <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a    <= win_a;
            alu_b    <= win_b;
            alu_ctrl <= ctrl_load;
            rsp_tag  <= win_tag;
            own      <= win;
            prio     <= ~win;
            state    <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= cap_result;
          rsp_zero   <= cap_zero;
          rsp_valid  <= own ? 2'b10 : 2'b01;
          state      <= RESP;
        end
        RESP: begin
          // Only the owner's rsp_ready can complete the response.
          if (rsp_ready[own]) begin
            rsp_valid <= 2'b00;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 2'b00;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter

module tb_alu_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0, req_a1, req_b0, req_b1;
  logic [3:0]  req_ctrl0, req_ctrl1;
  logic [3:0]  req_tag0, req_tag1;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_err;
  logic [3:0]  rsp_tag;

  int total = 0;
  int bad   = 0;

  alu_share_arbiter #(.TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_ctrl0(req_ctrl0), .req_ctrl1(req_ctrl1),
    .req_tag0(req_tag0), .req_tag1(req_tag1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .rsp_tag(rsp_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0100: return a ^ b;
      4'b0101: return a << b[4:0];
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1101: return 32'($signed(a) >>> b[4:0]);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic op_legal(input logic [3:0] c);
    case (c)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b0101, 4'b0110, 4'b0111, 4'b1101: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Stand-in for the shared combinational ALU
  assign alu_result = alu_ref(alu_a, alu_b, alu_ctrl);
  assign alu_zero   = (alu_result == 32'd0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic        own;
    logic [31:0] res;
    logic        zero;
    logic        err;
    logic [3:0]  tag;
  } sb_t;

  sb_t sb[$];

  // Reference state of the arbiter, advanced once per cycle at the falling edge
  typedef enum int {M_IDLE, M_EXEC, M_RESP} mstate_t;
  mstate_t     m_state = M_IDLE;
  logic        m_prio  = 1'b0;
  logic        m_own   = 1'b0;
  logic [31:0] e_a, e_b;
  logic [3:0]  e_ctrl;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_req_ready", req_ready, 2'b00);
        m_state = M_IDLE;
        m_prio  = 1'b0;
        m_own   = 1'b0;
        sb.delete();
      end else begin
        case (m_state)
          M_IDLE: begin
            logic [1:0] g;
            g = 2'b00;
            if (req_valid == 2'b01)      g = 2'b01;
            else if (req_valid == 2'b10) g = 2'b10;
            else if (req_valid == 2'b11) g = m_prio ? 2'b10 : 2'b01;
            chk("req_ready", req_ready, g);
            chk("idle_rsp_valid", rsp_valid, 2'b00);
            if (g != 2'b00) begin
              sb_t e;
              logic        w, leg;
              logic [31:0] a, b, r;
              logic [3:0]  c;
              w = g[1];
              a = w ? req_a1 : req_a0;
              b = w ? req_b1 : req_b0;
              c = w ? req_ctrl1 : req_ctrl0;
`ifdef ALU_ARB_OPCHECK_EN
              leg = op_legal(c);
`else
              leg = 1'b1;
`endif
              r      = alu_ref(a, b, c);
              e.own  = w;
              e.res  = leg ? r : 32'd0;
              e.zero = leg ? (r == 32'd0) : 1'b1;
              e.err  = ~leg;
              e.tag  = w ? req_tag1 : req_tag0;
              sb.push_back(e);
              e_a     = a;
              e_b     = b;
              e_ctrl  = leg ? c : 4'b0010;
              m_own   = w;
              m_prio  = ~w;
              m_state = M_EXEC;
            end
          end
          M_EXEC: begin
            chk("exec_req_ready", req_ready, 2'b00);
            chk("exec_rsp_valid", rsp_valid, 2'b00);
            chk("exec_alu_a", alu_a, e_a);
            chk("exec_alu_b", alu_b, e_b);
            chk("exec_alu_ctrl", alu_ctrl, e_ctrl);
            m_state = M_RESP;
          end
          default: begin
            chk("resp_req_ready", req_ready, 2'b00);
            chk("resp_rsp_valid", rsp_valid, m_own ? 2'b10 : 2'b01);
            chk("sb_depth", sb.size(), 1);
            if (sb.size() != 0) begin
              chk("sb_result", rsp_result, sb[0].res);
              chk("sb_zero", rsp_zero, sb[0].zero);
              chk("sb_err", rsp_err, sb[0].err);
              chk("sb_tag", rsp_tag, sb[0].tag);
            end
            if (rsp_ready[m_own]) begin
              if (sb.size() != 0) void'(sb.pop_front());
              m_state = M_IDLE;
            end
          end
        endcase
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, input logic [3:0] t);
    req_a0 = a; req_b0 = b; req_ctrl0 = c; req_tag0 = t;
  endtask

  task automatic drive1(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, input logic [3:0] t);
    req_a1 = a; req_b1 = b; req_ctrl1 = c; req_tag1 = t;
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (rsp_valid == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_arrive"}, 32'(rsp_valid != 2'b00), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_alu_a"}, alu_a, 32'd0);
    chk({tag, "_alu_b"}, alu_b, 32'd0);
    chk({tag, "_alu_ctrl"}, alu_ctrl, 4'b0010);
    chk({tag, "_rsp_result"}, rsp_result, 32'd0);
    chk({tag, "_rsp_zero"}, rsp_zero, 1'b0);
    chk({tag, "_rsp_err"}, rsp_err, 1'b0);
    chk({tag, "_rsp_tag"}, rsp_tag, 4'd0);
    chk({tag, "_rsp_valid"}, rsp_valid, 2'b00);
    chk({tag, "_req_ready"}, req_ready, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int seen1;
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    drive0(0, 0, 4'b0010, 0);
    drive1(0, 0, 4'b0010, 0);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_reset_outputs("por");
    tick;
    rst_n = 1'b1;
    tick;

    // Contention: grants must alternate 0,1,0
    drive0(32'd9, 32'd9, 4'b0110, 4'd1);
    drive1(32'hFFFF_FFFF, 32'd1, 4'b0111, 4'd2);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 3; k++) begin
      wait_rsp("cont");
      chk("cont_owner", rsp_valid, (k % 2 == 1) ? 2'b10 : 2'b01);
      chk("cont_result", rsp_result, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("cont_zero", rsp_zero, (k % 2 == 1) ? 1'b0 : 1'b1);
      chk("cont_tag", rsp_tag, (k % 2 == 1) ? 4'd2 : 4'd1);
    end
    tick;
    req_valid = 2'b00;
    tick;

    // Single request on requester 0: ADD 5+7
    drive0(32'd5, 32'd7, 4'b0010, 4'd3);
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    @(negedge clk);
    chk("single_ready", req_ready, 2'b01);
    tick;
    req_valid = 2'b00;
    @(negedge clk);
    chk("single_alu_ctrl", alu_ctrl, 4'b0010);
    @(negedge clk);
    chk("single_rsp_valid", rsp_valid, 2'b01);
    chk("single_result", rsp_result, 32'd12);
    chk("single_zero", rsp_zero, 1'b0);
    chk("single_tag", rsp_tag, 4'd3);
    tick;

    // Response backpressure on SRA. The non-owner's rsp_ready must be ignored.
    drive0(32'h8000_0000, 32'd4, 4'b1101, 4'd6);
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    tick;
    drive1(32'h0000_00F0, 32'h0000_000F, 4'b0001, 4'd5);
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    wait_rsp("bp");
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 2'b01);
      chk("bp_result", rsp_result, 32'hF800_0000);
      chk("bp_req_ready", req_ready, 2'b00);
    end
    tick;
    rsp_ready = 2'b01;
    @(negedge clk);
    chk("bp_last_resp", rsp_valid, 2'b01);
    @(negedge clk);
    chk("bp_idle_grant", req_ready, 2'b10);
    tick;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    wait_rsp("bp1");
    chk("bp1_owner", rsp_valid, 2'b10);
    chk("bp1_result", rsp_result, 32'h0000_00FF);
    chk("bp1_tag", rsp_tag, 4'd5);
    tick;

    // Illegal opcode
    drive0(32'd3, 32'd4, 4'b1111, 4'd9);
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    tick;
    req_valid = 2'b00;
    wait_rsp("ill");
`ifdef ALU_ARB_OPCHECK_EN
    chk("ill_err", rsp_err, 1'b1);
    chk("ill_result", rsp_result, 32'd0);
    chk("ill_zero", rsp_zero, 1'b1);
`else
    chk("ill_err", rsp_err, 1'b0);
    chk("ill_result", rsp_result, 32'hDEAD_BEEF);
`endif
    tick;

    // Requester 1 raises valid during EXEC and withdraws it before IDLE
    drive0(32'd1, 32'd1, 4'b0010, 4'd1);
    drive1(32'd2, 32'd2, 4'b0010, 4'd4);
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    tick;
    req_valid = 2'b10;
    @(negedge clk);
    chk("wd_exec_ready", req_ready, 2'b00);
    tick;
    req_valid = 2'b00;
    seen1 = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid[1] || req_ready[1]) seen1++;
    end
    chk("wd_no_grant1", seen1, 0);
    tick;

    // Reset while a response is pending
    drive0(32'd2, 32'd3, 4'b0010, 4'd7);
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    tick;
    req_valid = 2'b00;
    wait_rsp("mr");
    chk("mr_rsp_valid", rsp_valid, 2'b01);
    tick;
    rst_n = 1'b0;
    req_valid = 2'b11;
    @(negedge clk);
    chk_reset_outputs("mid");
    tick;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", req_ready, 2'b01);
    tick;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    wait_rsp("pr");
    chk("pr_owner", rsp_valid, 2'b01);
    chk("pr_result", rsp_result, 32'd5);
    repeat (4) tick;
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
